// File: rtl/canny_nms_if.sv
// Column stream into the non-maximum suppression stage and its suppressed-magnitude result.
// master drives columns and reads results; slave is the NMS stage.
interface canny_nms_if;
  logic       enable;
  logic [4:0] mag_in1;
  logic [4:0] mag_in2;
  logic [4:0] mag_in3;
  logic [1:0] angle_in;
  logic [4:0] mag_out;
  logic       readable;
  logic       done;

  modport master (
    output enable, mag_in1, mag_in2, mag_in3, angle_in,
    input  mag_out, readable, done
  );

  modport slave (
    input  enable, mag_in1, mag_in2, mag_in3, angle_in,
    output mag_out, readable, done
  );
endinterface

// File: rtl/canny_nms.sv
// Non-maximum suppression over a sliding 3x3 magnitude window, one column per accepted enable.
// Result one edge after the completing accept; no backpressure, enable is ignored once the image is done.
module canny_nms #(
  parameter int IMG_W       = 16,
  parameter int NUM_STRIPES = 14
) (
  input  logic        clk,
  input  logic        reset,
  canny_nms_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW = $clog2(NUM_STRIPES + 1);

  localparam logic [CW-1:0] LAST_COL    = CW'(IMG_W - 1);
  localparam logic [SW-1:0] LAST_STRIPE = SW'(NUM_STRIPES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Index 0 is row 0 (top), index 2 is row 2 (bottom).
  logic [2:0][4:0] col0, col1, col2;
  logic [1:0]      ang1, ang2;
  logic [CW-1:0]   col_cnt;
  logic [SW-1:0]   stripe_cnt;
  logic            win_new;

  logic            accept;
  logic            last_col;
  logic            last_stripe;

  logic [4:0]      nb_a, nb_b;
  logic [4:0]      nms_val;

  logic [4:0]      mag_out_q;
  logic            readable_q;
  logic            done_q;

  assign last_col    = (col_cnt == LAST_COL);
  assign last_stripe = (stripe_cnt == LAST_STRIPE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, RUN: begin
        accept = bus.enable;
        if (bus.enable) begin
          state_nxt = (last_col && last_stripe) ? DONE : RUN;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Window shift and per-stripe column bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col0       <= '0;
      col1       <= '0;
      col2       <= '0;
      ang1       <= '0;
      ang2       <= '0;
      col_cnt    <= '0;
      stripe_cnt <= '0;
      win_new    <= 1'b0;
    end else begin
      win_new <= accept && (col_cnt >= CW'(2));
      if (accept) begin
        col0 <= col1;
        col1 <= col2;
        col2 <= {bus.mag_in3, bus.mag_in2, bus.mag_in1};
        ang1 <= ang2;
        ang2 <= bus.angle_in;
        if (last_col) begin
          col_cnt    <= '0;
          stripe_cnt <= stripe_cnt + SW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  // Neighbour pick along the quantised gradient; y axis points toward row 0.
  always_comb begin
    nb_a = col0[1];
    nb_b = col2[1];
    case (ang1)
      2'b00: begin nb_a = col0[1]; nb_b = col2[1]; end
      2'b01: begin nb_a = col2[0]; nb_b = col0[2]; end
      2'b10: begin nb_a = col1[0]; nb_b = col1[2]; end
      2'b11: begin nb_a = col0[0]; nb_b = col2[2]; end
      default: ;
    endcase
    nms_val = ((col1[1] >= nb_a) && (col1[1] >= nb_b)) ? col1[1] : 5'd0;
  end

  // Samples the window as left by the previous accept, so a shift this edge cannot corrupt it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_out_q  <= '0;
      readable_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (win_new) begin
        mag_out_q <= nms_val;
      end
      readable_q <= win_new;
      done_q     <= (state == DONE);
    end
  end

  assign bus.mag_out  = mag_out_q;
  assign bus.readable = readable_q;
  assign bus.done     = done_q;

endmodule

// File: doc/canny_nms.md
# canny_nms

Non-maximum suppression stage of the edge-detection pipeline, directly downstream of the Sobel stage. It receives gradient magnitudes (5-bit) and quantised gradient angles (2-bit) one column of three rows at a time. It keeps a 3×3 magnitude window and emits the centre magnitude when that magnitude is a local maximum along the gradient direction, otherwise 0. Image traversal is stripe-by-stripe: each stripe is IMG_W columns of 3 rows, and the main control unit supplies the columns.

## Interface
- IMG_W, 16: columns per stripe (≥3).
- NUM_STRIPES, 14: stripes per image (image height − 2).
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  =1: column on mag_in*/angle_in is valid and is accepted this edge.
- mag_in1  input  5  magnitude, row 0 (top) of the incoming column.
- mag_in2  input  5  magnitude, row 1 (centre).
- mag_in3  input  5  magnitude, row 2 (bottom).
- angle_in  input  2  angle of the row-1 pixel of the incoming column: 00=0°, 01=45°, 10=90°, 11=135°.
- mag_out  output  5  suppressed magnitude, registered.
- readable  output  1  one-cycle pulse: mag_out holds a new result.
- done  output  1  sticky: the whole image has been processed.

## Operation
- Window: three columns (col0 oldest, col2 newest) × rows 0..2, 5-bit unsigned. Per-column angle registers are kept for col1 and col2.
- On an edge with enable=1 in RUN: col0←col1, col1←col2, col2←{mag_in1,mag_in2,mag_in3}, and the angles shift the same way. With enable=0 the window holds; there is no implicit shifting.
- col_cnt (0..IMG_W−1) counts the columns accepted in the current stripe. After the accept with col_cnt=IMG_W−1 it wraps to 0 and stripe_cnt increments. The window is not cleared on wrap; old columns are ignored by the col_cnt gating.
- win_new is registered. It is set on an accept when col_cnt≥2 before the increment, i.e. the window now holds three columns of the same stripe. Otherwise it is cleared.
- NMS uses centre C=col1.row1 and the col1 angle, with the y-axis toward row 0:
  - 00: neighbours col0.row1 and col2.row1.
  - 10: neighbours col1.row0 and col1.row2.
  - 01: neighbours col2.row0 and col0.row2.
  - 11: neighbours col0.row0 and col2.row2.
- Result = C if C≥both neighbours (ties keep), else 0. The comparison is unsigned 5-bit with no scaling.
- FSM states:
  - IDLE (reset): first enable=1 accepts the column and enters RUN.
  - RUN: accepts columns as above.
  - DONE: entered on the accept of column IMG_W−1 of stripe NUM_STRIPES−1. In DONE, enable is ignored, the window freezes, and counters hold. The state remains until reset.
- Reset mid-operation clears the window, counters, win_new and outputs, and returns to IDLE. There is no partial-stripe recovery.

## Timing
- Reset values: mag_out=0, readable=0, done=0, window=0, col_cnt=0, stripe_cnt=0, state=IDLE.
- Latency: a column accepted at edge E (with col_cnt≥2) produces mag_out and readable=1 after edge E+1.
- mag_out updates only when win_new=1 and holds otherwise. readable equals the registered win_new, so it is high for exactly one cycle per window.
- An accept at E+1 does not disturb the result of E, because the output samples the pre-shift window. Back-to-back enables therefore give one result per cycle.
- Each stripe yields exactly IMG_W−2 readable pulses. There are no pulses for the first two accepts of a stripe.
- done rises after the edge following the final accept. This is the same cycle as the final readable pulse.

## Test plan
- Reset → all outputs 0; no readable for 2 accepts after reset; readable first after the 3rd accept +1 edge.
- Columns (row0,row1,row2) c0=(1,5,2), c1=(3,9,4), c2=(6,7,8), c1 angle 00 → mag_out=9. With c1=(3,6,4), angle 00 → 0 (6<7). With c1=(3,6,4), angle 10 → 6.
- c0=(10,0,2), c1=(0,8,0), c2=(3,0,12): angle 11 → 0; angle 01 → 8. Tie case c1.row1=12 with angle 11 → 12.
- enable toggled 1,0,0,1 mid-stripe → no readable during gaps; mag_out holds its previous value; the next result uses the correct window.
- IMG_W=16: feed 16 columns → exactly 14 readable pulses. The first 2 columns of the next stripe → no pulse; the 3rd → pulse with a window of new-stripe data only.
- Feed 14 full stripes → done=1 with the 196th pulse. Further enables change nothing. Assert reset mid-stripe → outputs 0, IDLE, restart is clean.
